// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART packet framing constants, state encoding and error causes
package uart_pkg;

    localparam logic [7:0] HEADER_DEF = 8'hAA;

    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_LEN  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;
    localparam logic [1:0] ST_CHK  = 2'd3;

    // Error causes; the TX-side packet builder uses the same codes
    typedef enum logic [2:0] {
        ERR_NONE = 3'd0,
        ERR_CHK  = 3'd1,
        ERR_LEN  = 3'd2,
        ERR_FRM  = 3'd3,
        ERR_TMO  = 3'd4
    } err_cause_t;

endpackage

// File: rtl/uart_tmo_cnt.sv
// rtl/uart_tmo_cnt.sv - inter-byte timeout counter with a one-cycle expiry pulse
module uart_tmo_cnt #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // A byte arriving on the terminal count suppresses the expiry
    assign expire = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - frames HEADER/LEN/payload/CHK byte packets into parallel command words
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int         MAX_LEN     = 4,
    parameter logic [7:0] HEADER      = HEADER_DEF,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   rx_err,
    output logic [8*MAX_LEN-1:0]   pkt_data,
    output logic [3:0]             pkt_len,
    output logic                   pkt_valid,
    output logic                   chk_err,
    output logic                   len_err,
    output logic                   frm_err,
    output logic                   tmo_err,
    output logic                   busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    logic [1:0]           state;
    logic [1:0]           state_nx;
    logic [3:0]           len_q;
    logic [3:0]           idx;
    logic [7:0]           acc;
    logic [7:0]           buf_q [MAX_LEN];
    logic [8*MAX_LEN-1:0] buf_flat;
    logic                 len_ok;
    logic                 pkt_ok;
    logic                 tmo_expire;
    err_cause_t           cause;

    uart_tmo_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (busy),
        .clr    (rx_valid),
        .expire (tmo_expire)
    );

    assign len_ok = (rx_data != 8'd0) && (rx_data <= MAX_LEN_B);

    always_comb begin
        buf_flat = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            buf_flat[8*i +: 8] = buf_q[i];
        end
    end

    // Framing errors outrank length/checksum checks; timeout only on idle cycles
    always_comb begin
        state_nx = state;
        cause    = ERR_NONE;
        pkt_ok   = 1'b0;
        if (rx_valid) begin
            case (state)
                ST_HUNT: if (!rx_err && rx_data == HEADER) state_nx = ST_LEN;
                ST_LEN: begin
                    if (rx_err)      cause    = ERR_FRM;
                    else if (len_ok) state_nx = ST_PAY;
                    else             cause    = ERR_LEN;
                end
                ST_PAY: begin
                    if (rx_err)                    cause    = ERR_FRM;
                    else if (idx == len_q - 4'd1)  state_nx = ST_CHK;
                end
                default: begin
                    if (rx_err)              cause  = ERR_FRM;
                    else if (rx_data == acc) pkt_ok = 1'b1;
                    else                     cause  = ERR_CHK;
                end
            endcase
        end else if (tmo_expire) begin
            cause = ERR_TMO;
        end
        if (cause != ERR_NONE || pkt_ok) state_nx = ST_HUNT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HUNT;
            busy      <= 1'b0;
            len_q     <= '0;
            idx       <= '0;
            acc       <= '0;
            pkt_data  <= '0;
            pkt_len   <= '0;
            pkt_valid <= 1'b0;
            chk_err   <= 1'b0;
            len_err   <= 1'b0;
            frm_err   <= 1'b0;
            tmo_err   <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= '0;
        end else begin
            state     <= state_nx;
            busy      <= (state_nx != ST_HUNT);
            pkt_valid <= pkt_ok;
            chk_err   <= (cause == ERR_CHK);
            len_err   <= (cause == ERR_LEN);
            frm_err   <= (cause == ERR_FRM);
            tmo_err   <= (cause == ERR_TMO);
            if (rx_valid && !rx_err) begin
                case (state)
                    ST_HUNT: if (rx_data == HEADER) acc <= '0;
                    ST_LEN: begin
                        if (len_ok) begin
                            len_q <= rx_data[3:0];
                            acc   <= rx_data;
                            idx   <= '0;
                            for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= '0;
                        end
                    end
                    ST_PAY: begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (idx == 4'(i)) buf_q[i] <= rx_data;
                        end
                        acc <= acc ^ rx_data;
                        idx <= idx + 4'd1;
                    end
                    default: ;
                endcase
            end
            if (pkt_ok) begin
                pkt_data <= buf_flat;
                pkt_len  <= len_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed table-driven bench for uart_cmd_parser
module tb_uart_cmd_parser;

    localparam int MAX_LEN = 4;
    localparam int TMO     = 32;

    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_PKT  = 5'b10000;
    localparam logic [4:0] S_CHK  = 5'b01000;
    localparam logic [4:0] S_LEN  = 5'b00100;
    localparam logic [4:0] S_FRM  = 5'b00010;
    localparam logic [4:0] S_TMO  = 5'b00001;

    typedef struct {
        logic [7:0]  data;
        logic        err;
        logic [4:0]  exp_str;
        logic        exp_busy;
        logic        chk_pkt;
        logic [31:0] exp_data;
        logic [3:0]  exp_len;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_err = 1'b0;
    logic [31:0] pkt_data;
    logic [3:0]  pkt_len;
    logic        pkt_valid, chk_err, len_err, frm_err, tmo_err, busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    uart_cmd_parser #(
        .MAX_LEN(MAX_LEN),
        .HEADER(8'hAA),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .pkt_data(pkt_data), .pkt_len(pkt_len), .pkt_valid(pkt_valid), .chk_err(chk_err),
        .len_err(len_err), .frm_err(frm_err), .tmo_err(tmo_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] strobes();
        return {pkt_valid, chk_err, len_err, frm_err, tmo_err};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic add(input logic [7:0] d, input logic e, input logic [4:0] s, input logic b,
                       input logic cp, input logic [31:0] pd, input logic [3:0] pl);
        vec_t v;
        v.data = d; v.err = e; v.exp_str = s; v.exp_busy = b;
        v.chk_pkt = cp; v.exp_data = pd; v.exp_len = pl;
        vecs.push_back(v);
    endtask

    task automatic send(input logic [7:0] d, input logic e);
        rx_data  = d;
        rx_err   = e;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle_strobes", 64'(strobes()), 64'(S_NONE));
        end
    endtask

    initial begin
        int n;
        // good packet, XOR 03^11^22^33 = 03
        add(8'hAA, 0, S_NONE, 1, 0, 0, 0);
        add(8'h03, 0, S_NONE, 1, 0, 0, 0);
        add(8'h11, 0, S_NONE, 1, 0, 0, 0);
        add(8'h22, 0, S_NONE, 1, 0, 0, 0);
        add(8'h33, 0, S_NONE, 1, 0, 0, 0);
        add(8'h03, 0, S_PKT,  0, 1, 32'h00332211, 4'd3);
        // bad checksum, expected 31
        add(8'hAA, 0, S_NONE, 1, 0, 0, 0);
        add(8'h02, 0, S_NONE, 1, 0, 0, 0);
        add(8'h55, 0, S_NONE, 1, 0, 0, 0);
        add(8'h66, 0, S_NONE, 1, 0, 0, 0);
        add(8'h00, 0, S_CHK,  0, 1, 32'h00332211, 4'd3);
        // length errors then a one-byte packet
        add(8'hAA, 0, S_NONE, 1, 0, 0, 0);
        add(8'h00, 0, S_LEN,  0, 0, 0, 0);
        add(8'hAA, 0, S_NONE, 1, 0, 0, 0);
        add(8'h05, 0, S_LEN,  0, 0, 0, 0);
        add(8'hAA, 0, S_NONE, 1, 0, 0, 0);
        add(8'h01, 0, S_NONE, 1, 0, 0, 0);
        add(8'h7E, 0, S_NONE, 1, 0, 0, 0);
        add(8'h7F, 0, S_PKT,  0, 1, 32'h0000007E, 4'd1);
        // framing error, then garbage in HUNT
        add(8'hAA, 0, S_NONE, 1, 0, 0, 0);
        add(8'h02, 0, S_NONE, 1, 0, 0, 0);
        add(8'h10, 1, S_FRM,  0, 1, 32'h0000007E, 4'd1);
        add(8'h12, 0, S_NONE, 0, 0, 0, 0);
        add(8'h34, 0, S_NONE, 0, 0, 0, 0);
        add(8'hAA, 1, S_NONE, 0, 0, 0, 0);
        // header byte as payload: 02^AA^01 = A9
        add(8'hAA, 0, S_NONE, 1, 0, 0, 0);
        add(8'h02, 0, S_NONE, 1, 0, 0, 0);
        add(8'hAA, 0, S_NONE, 1, 0, 0, 0);
        add(8'h01, 0, S_NONE, 1, 0, 0, 0);
        add(8'hA9, 0, S_PKT,  0, 1, 32'h000001AA, 4'd2);
        // MAX_LEN packet: 04^01^02^03^04 = 00
        add(8'hAA, 0, S_NONE, 1, 0, 0, 0);
        add(8'h04, 0, S_NONE, 1, 0, 0, 0);
        add(8'h01, 0, S_NONE, 1, 0, 0, 0);
        add(8'h02, 0, S_NONE, 1, 0, 0, 0);
        add(8'h03, 0, S_NONE, 1, 0, 0, 0);
        add(8'h04, 0, S_NONE, 1, 0, 0, 0);
        add(8'h00, 0, S_PKT,  0, 1, 32'h04030201, 4'd4);

        repeat (2) @(posedge clk);
        #1;
        check("reset_strobes", 64'(strobes()), 64'(S_NONE));
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_pkt_data", 64'(pkt_data), 64'd0);
        rst_n = 1'b1;
        idle(TMO + 8);

        foreach (vecs[i]) begin
            send(vecs[i].data, vecs[i].err);
            check($sformatf("vec%0d_strobes", i), 64'(strobes()), 64'(vecs[i].exp_str));
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
            if (vecs[i].chk_pkt) begin
                check($sformatf("vec%0d_pkt_data", i), 64'(pkt_data), 64'(vecs[i].exp_data));
                check($sformatf("vec%0d_pkt_len", i), 64'(pkt_len), 64'(vecs[i].exp_len));
            end
        end

        // timeout: tmo_err exactly TMO cycles after the last byte
        send(8'hAA, 0); send(8'h02, 0); send(8'h01, 0);
        n = 0;
        for (int i = 1; i <= 2 * TMO; i++) begin
            @(posedge clk);
            #1;
            if (n == 0 && strobes() != S_NONE) n = i;
        end
        check("tmo_latency", 64'(n), 64'(TMO));
        check("tmo_busy", 64'(busy), 64'd0);

        // byte on the expiry cycle wins
        send(8'hAA, 0); send(8'h02, 0); send(8'h01, 0);
        idle(TMO - 1);
        send(8'h02, 0);
        check("tmo_race_strobes", 64'(strobes()), 64'(S_NONE));
        check("tmo_race_busy", 64'(busy), 64'd1);
        send(8'h01, 0);
        check("tmo_race_pkt", 64'(strobes()), 64'(S_PKT));
        check("tmo_race_data", 64'(pkt_data), 64'h00000201);

        // reset during PAY
        send(8'hAA, 0); send(8'h03, 0); send(8'h11, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_strobes", 64'(strobes()), 64'(S_NONE));
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_data", 64'(pkt_data), 64'd0);
        check("midrst_len", 64'(pkt_len), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(8'h22, 0);
        check("midrst_hunt", 64'(busy), 64'd0);

        // back-to-back packets with no gap
        send(8'hAA, 0); send(8'h01, 0); send(8'h55, 0); send(8'h54, 0);
        check("b2b_pkt1", 64'(strobes()), 64'(S_PKT));
        check("b2b_data1", 64'(pkt_data), 64'h00000055);
        send(8'hAA, 0);
        check("b2b_hdr_busy", 64'(busy), 64'd1);
        send(8'h02, 0); send(8'h10, 0); send(8'h20, 0); send(8'h32, 0);
        check("b2b_pkt2", 64'(strobes()), 64'(S_PKT));
        check("b2b_data2", 64'(pkt_data), 64'h00002010);
        check("b2b_len2", 64'(pkt_len), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
